dm_cache_ctrl: RTL and testbench

DM_CACHE_CTRL -- requirements
Module: dm_cache_ctrl

---
 rtl/dm_cache_ctrl.sv | 107 ++++++++++
 tb/tb_dm_cache_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/dm_cache_ctrl.sv
// dm_cache_ctrl: direct-mapped, write-back, write-allocate cache controller
// Ports: clk, reset (sync, active-high);
//   cpu_address/cpu_write_data/cpu_read/cpu_write in, cpu_read_data/cpu_busy_wait out;
//   mem_address/mem_write_data/mem_read/mem_write out (registered), mem_read_data/mem_busy_wait in.
module dm_cache_ctrl #(
  parameter int NUM_LINES = 8,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_address,
  input  logic [31:0] cpu_write_data,
  input  logic        cpu_read,
  input  logic        cpu_write,
  output logic [31:0] cpu_read_data,
  output logic        cpu_busy_wait,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_read_data,
  input  logic        mem_busy_wait
);
  localparam int WB = $clog2(WORDS_PER_LINE);
  localparam int IB = $clog2(NUM_LINES);
  localparam int TW = 30 - IB - WB;
  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, UPDATE} state_t;
  state_t state, state_n;
  logic [WB-1:0] beat, beat_n, word;
  logic [IB-1:0] index;
  logic [TW-1:0] req_tag;
  logic [31:0] data [NUM_LINES][WORDS_PER_LINE];
  logic [TW-1:0] tags [NUM_LINES];
  logic [NUM_LINES-1:0] valid, dirty;
  logic req, hit, done, unused;
  logic mem_read_n, mem_write_n;
  logic [31:0] mem_address_n, mem_write_data_n;
  assign word = cpu_address[WB+1:2];
  assign index = cpu_address[IB+WB+1:WB+2];
  assign req_tag = cpu_address[31:IB+WB+2];
  assign unused = ^cpu_address[1:0];
  assign req = cpu_read | cpu_write;
  assign hit = req & valid[index] & (tags[index] == req_tag);
  assign done = (mem_read | mem_write) & ~mem_busy_wait;
  assign cpu_busy_wait = (state != IDLE) | (req & ~hit);
  assign cpu_read_data = data[index][word];
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      beat <= '0;
      mem_read <= 1'b0;
      mem_write <= 1'b0;
      mem_address <= '0;
      mem_write_data <= '0;
      valid <= '0;
      dirty <= '0;
    end else begin
      state <= state_n;
      beat <= beat_n;
      mem_read <= mem_read_n;
      mem_write <= mem_write_n;
      mem_address <= mem_address_n;
      mem_write_data <= mem_write_data_n;
      if (state == IDLE && hit && cpu_write) dirty[index] <= 1'b1;
      if (state == UPDATE) begin
        valid[index] <= 1'b1;
        dirty[index] <= 1'b0;
      end
    end
  end
  // storage arrays carry no reset; writes are merely suppressed on a reset edge
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == IDLE && hit && cpu_write) data[index][word] <= cpu_write_data;
      if (state == ALLOCATE && done) data[index][beat] <= mem_read_data;
      if (state == UPDATE) tags[index] <= req_tag;
    end
  end
  always_comb begin
    state_n = state;
    beat_n = beat;
    case (state)
      IDLE: if (req && !hit) begin
        if (valid[index] && dirty[index]) state_n = WRITEBACK;
        else state_n = ALLOCATE;
        beat_n = '0;
      end
      WRITEBACK: if (done) begin
        beat_n = beat + WB'(1);
        if (&beat) state_n = ALLOCATE;
      end
      ALLOCATE: if (done) begin
        beat_n = beat + WB'(1);
        if (&beat) state_n = UPDATE;
      end
      default: state_n = IDLE;
    endcase
  end
  // memory outputs are computed from the next state/beat so the registers line up with it
  always_comb begin
    mem_read_n = state_n == ALLOCATE;
    mem_write_n = state_n == WRITEBACK;
    mem_address_n = mem_write_n ? {tags[index], index, beat_n, 2'b00} :
                    mem_read_n ? {req_tag, index, beat_n, 2'b00} : '0;
    mem_write_data_n = mem_write_n ? data[index][beat_n] : '0;
  end
endmodule

// File: tb/tb_dm_cache_ctrl.sv
// tb_dm_cache_ctrl: directed table-driven bench for dm_cache_ctrl with a stalling memory model
module tb_dm_cache_ctrl;
  logic clk = 1'b0, reset = 1'b1;
  logic [31:0] cpu_address = '0, cpu_write_data = '0;
  logic cpu_read = 1'b0, cpu_write = 1'b0;
  logic [31:0] cpu_read_data, mem_address, mem_write_data, mem_read_data;
  logic cpu_busy_wait, mem_read, mem_write, mem_busy_wait;
  logic mem_init = 1'b1;
  int stall = 0, cnt = 0, log_n = 0, n_chk = 0, n_fail = 0;
  logic [31:0] mem [256];
  logic [31:0] log_a [256];
  logic [31:0] log_d [256];
  logic log_w [256];
  logic prev_stall = 1'b0, stall_bad = 1'b0, stall_seen = 1'b0, both_bad = 1'b0;
  logic [31:0] prev_addr = '0, prev_data = '0;
  logic act;

  dm_cache_ctrl dut (
    .clk(clk), .reset(reset),
    .cpu_address(cpu_address), .cpu_write_data(cpu_write_data),
    .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_read_data(cpu_read_data), .cpu_busy_wait(cpu_busy_wait),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_read_data(mem_read_data), .mem_busy_wait(mem_busy_wait)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memv(int i);
    return (i >= 16 && i < 20) ? 32'h11111111 * (i - 15) : {16'hD00D, 16'(i)};
  endfunction

  assign act = mem_read | mem_write;
  assign mem_busy_wait = act && (cnt < stall);
  assign mem_read_data = mem[mem_address[9:2]];

  always @(posedge clk) begin
    if (mem_init) for (int i = 0; i < 256; i++) mem[i] <= memv(i);
    if (act && !mem_busy_wait) begin
      if (mem_write) mem[mem_address[9:2]] <= mem_write_data;
      log_a[log_n % 256] <= mem_address;
      log_d[log_n % 256] <= mem_write_data;
      log_w[log_n % 256] <= mem_write;
      log_n <= log_n + 1;
      cnt <= 0;
    end else if (act) cnt <= cnt + 1;
    else cnt <= 0;
    if (act && prev_stall && (mem_address != prev_addr || (mem_write && mem_write_data != prev_data)))
      stall_bad <= 1'b1;
    if (act && mem_busy_wait) stall_seen <= 1'b1;
    if (mem_read && mem_write) both_bad <= 1'b1;
    prev_stall <= act && mem_busy_wait;
    prev_addr <= mem_address;
    prev_data <= mem_write_data;
  end

  task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    n_chk++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act_v, exp_v);
    end
  endtask

  typedef struct {
    logic rd, wr;
    logic [31:0] addr, wd, rdata;
    logic crd, hit;
    int nr, nw;
    logic [31:0] rb, wb;
  } vec_t;
  vec_t tv [10];

  task automatic run(input vec_t v);
    int start, nr, nw;
    start = log_n;
    cpu_read = v.rd;
    cpu_write = v.wr;
    cpu_address = v.addr;
    cpu_write_data = v.wd;
    #1;
    chk($sformatf("hit@%h", v.addr), {31'b0, !cpu_busy_wait}, {31'b0, v.hit});
    for (int c = 0; c < 300 && cpu_busy_wait; c++) @(negedge clk);
    chk($sformatf("busy_timeout@%h", v.addr), {31'b0, cpu_busy_wait}, 32'h0);
    if (v.crd) chk($sformatf("rdata@%h", v.addr), cpu_read_data, v.rdata);
    @(posedge clk);
    @(negedge clk);
    cpu_read = 1'b0;
    cpu_write = 1'b0;
    nr = 0;
    nw = 0;
    for (int k = start; k < log_n; k++) begin
      if (log_w[k % 256]) begin
        chk($sformatf("wb_addr@%h", v.addr), log_a[k % 256], v.wb + 32'(4 * nw));
        nw++;
      end else begin
        chk($sformatf("rd_addr@%h", v.addr), log_a[k % 256], v.rb + 32'(4 * nr));
        nr++;
      end
    end
    chk($sformatf("n_reads@%h", v.addr), 32'(nr), 32'(v.nr));
    chk($sformatf("n_writes@%h", v.addr), 32'(nw), 32'(v.nw));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int start;
    vec_t v;
    tv[0] = '{1, 0, 32'h40, 0, 32'h11111111, 1, 0, 4, 0, 32'h40, 0};
    tv[1] = '{1, 0, 32'h44, 0, 32'h22222222, 1, 1, 0, 0, 0, 0};
    tv[2] = '{0, 1, 32'h48, 32'hABCDE123, 0, 0, 1, 0, 0, 0, 0};
    tv[3] = '{1, 0, 32'h48, 0, 32'hABCDE123, 1, 1, 0, 0, 0, 0};
    tv[4] = '{1, 0, 32'hC0, 0, 32'hD00D0030, 1, 0, 4, 4, 32'hC0, 32'h40};
    tv[5] = '{1, 0, 32'hCC, 0, 32'hD00D0033, 1, 1, 0, 0, 0, 0};
    tv[6] = '{1, 1, 32'hC4, 32'h5555AAAA, 0, 0, 1, 0, 0, 0, 0};
    tv[7] = '{1, 0, 32'hC4, 0, 32'h5555AAAA, 1, 1, 0, 0, 0, 0};
    tv[8] = '{1, 0, 32'h00, 0, 32'hD00D0000, 1, 0, 4, 0, 32'h00, 0};
    tv[9] = '{1, 0, 32'h4C, 0, 32'h44444444, 1, 0, 4, 4, 32'h40, 32'hC0};
    @(negedge clk);
    mem_init = 1'b0;
    @(negedge clk);
    chk("rst_mem_read", {31'b0, mem_read}, 32'h0);
    chk("rst_mem_write", {31'b0, mem_write}, 32'h0);
    chk("rst_mem_address", mem_address, 32'h0);
    chk("rst_mem_write_data", mem_write_data, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_busy", {31'b0, cpu_busy_wait}, 32'h0);
    for (int i = 0; i < 10; i++) run(tv[i]);
    chk("mem_48_written_back", mem[8'h12], 32'hABCDE123);
    chk("mem_C4_written_back", mem[8'h31], 32'h5555AAAA);
    v = '{0, 1, 32'h44, 32'h77778888, 0, 0, 1, 0, 0, 0, 0};
    run(v);
    stall = 3;
    v = '{1, 0, 32'hC8, 0, 32'hD00D0032, 1, 0, 4, 4, 32'hC0, 32'h40};
    run(v);
    stall = 0;
    chk("stall_stable", {31'b0, stall_bad}, 32'h0);
    chk("stall_seen", {31'b0, stall_seen}, 32'h1);
    chk("mem_44_written_back", mem[8'h11], 32'h77778888);
    start = log_n;
    cpu_read = 1'b1;
    cpu_address = 32'h40;
    for (int c = 0; c < 100 && (log_n - start) < 2; c++) @(negedge clk);
    chk("alloc_beat2_read", {31'b0, mem_read}, 32'h1);
    chk("alloc_beat2_addr", mem_address, 32'h48);
    reset = 1'b1;
    cpu_read = 1'b0;
    @(negedge clk);
    chk("abort_mem_read", {31'b0, mem_read}, 32'h0);
    chk("abort_mem_write", {31'b0, mem_write}, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    v = '{1, 0, 32'h44, 0, 32'h77778888, 1, 0, 4, 0, 32'h40, 0};
    run(v);
    chk("never_rd_and_wr", {31'b0, both_bad}, 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
